// File: rtl/coin_front_if.sv
// coin_front_if: coin/button sensor inputs and selection/coin outputs between the front end and its environment
interface coin_front_if;
  logic       coin5_in;
  logic       coin10_in;
  logic       btn_a;
  logic       btn_b;
  logic [1:0] drinks_out;
  logic       sel;
  logic [1:0] din;
  logic       sel_valid;
  logic       coin_reject;
  modport slave (
    input  coin5_in, coin10_in, btn_a, btn_b, drinks_out,
    output sel, din, sel_valid, coin_reject
  );
  modport master (
    output coin5_in, coin10_in, btn_a, btn_b, drinks_out,
    input  sel, din, sel_valid, coin_reject
  );
endinterface

// File: rtl/coin_front.sv
// coin_front: synchronizes and debounces coin/button inputs and sequences selection and payment for the vending FSM
module coin_front #(
  parameter int DEB_CYCLES = 4
) (
  input logic         clk,
  input logic         rst_n,
  coin_front_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SELECTED, PAYING} state_t;
  localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);
  logic [3:0]      w_raw, r_sync1, r_sync2;
  logic [1:0]      r_deb, r_deb_d, r_cev, r_bprev, r_bev;
  logic [1:0][7:0] r_cnt;
  state_t          r_state, w_next;
  logic            r_sel, w_sel, r_valid, r_rej, w_rej;
  logic [1:0]      r_din, w_din;
  logic            w_c5, w_c10, w_one_coin, w_one_btn;
  assign w_raw      = {bus.btn_b, bus.btn_a, bus.coin10_in, bus.coin5_in};
  assign w_c5       = r_cev[0];
  assign w_c10      = r_cev[1];
  assign w_one_coin = w_c5 ^ w_c10;
  assign w_one_btn  = r_bev[0] ^ r_bev[1];
  // two-flop synchronizer on every raw sensor and button
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  // coin debounce: level flips only after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (r_sync2[i] == r_deb[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + 8'd1;
    end
  // rising-edge event registers for debounced coins and synchronized buttons
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_deb_d <= '0;
      r_cev   <= '0;
      r_bprev <= '0;
      r_bev   <= '0;
    end else begin
      r_deb_d <= r_deb;
      r_cev   <= r_deb & ~r_deb_d;
      r_bprev <= r_sync2[3:2];
      r_bev   <= r_sync2[3:2] & ~r_bprev;
    end
  // transaction state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_din   <= 2'd0;
      r_rej   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sel   <= w_sel;
      r_valid <= (w_next != IDLE);
      r_din   <= w_din;
      r_rej   <= w_rej;
    end
  // next state: simultaneous coins are always bounced; a coin in SELECTED wins over a same-cycle button so sel settles before din
  always_comb begin
    w_next = r_state;
    w_sel  = r_sel;
    w_din  = 2'd0;
    w_rej  = 1'b0;
    if (w_c5 & w_c10) w_rej = 1'b1;
    else
      case (r_state)
        IDLE: begin
          w_rej = w_one_coin;
          if (w_one_btn) begin
            w_sel  = r_bev[1];
            w_next = SELECTED;
          end
        end
        SELECTED:
          if (w_one_coin) begin
            w_din  = {w_c10, w_c5};
            w_next = PAYING;
          end else if (w_one_btn) w_sel = r_bev[1];
        PAYING:
          if (bus.drinks_out != 2'd0) begin
            w_rej  = w_one_coin;
            w_next = IDLE;
          end else if (w_one_coin) w_din = {w_c10, w_c5};
        default: w_next = IDLE;
      endcase
  end
  assign bus.sel         = r_sel;
  assign bus.sel_valid   = r_valid;
  assign bus.din         = r_din;
  assign bus.coin_reject = r_rej;
endmodule

// File: tb/tb_coin_front.sv
// tb_coin_front: directed and randomized checks of coin_front against a cycle-history reference model
module tb_coin_front;
  localparam int D = 4;
  localparam int N = 16384;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  coin_front_if bus();
  coin_front #(.DEB_CYCLES(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  // reference model: per-cycle raw input history; a debounced level flips when the last D synchronized samples all disagree with it
  bit h5[N], h10[N], ha[N], hb[N], d5[N], d10[N];
  int cyc = 300;
  int m_state = 0;
  logic m_sel = 1'b0, m_valid = 1'b0, m_rej = 1'b0;
  logic [1:0] m_din = 2'd0;
  int n;
  bit f5, f10, ev5, ev10, ea, eb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_sel = 1'b0; m_valid = 1'b0; m_din = 2'd0; m_rej = 1'b0;
      for (int k = 0; k < D + 6; k++) begin
        h5[cyc-k] = 0; h10[cyc-k] = 0; ha[cyc-k] = 0; hb[cyc-k] = 0; d5[cyc-k] = 0; d10[cyc-k] = 0;
      end
    end else begin
      cyc++;
      n = cyc;
      h5[n] = bus.coin5_in; h10[n] = bus.coin10_in; ha[n] = bus.btn_a; hb[n] = bus.btn_b;
      f5 = 1; f10 = 1;
      for (int k = 2; k <= D + 1; k++) begin
        if (h5[n-k] == d5[n-1]) f5 = 0;
        if (h10[n-k] == d10[n-1]) f10 = 0;
      end
      d5[n]  = f5 ? !d5[n-1] : d5[n-1];
      d10[n] = f10 ? !d10[n-1] : d10[n-1];
      ev5  = d5[n-2] && !d5[n-3];
      ev10 = d10[n-2] && !d10[n-3];
      ea   = ha[n-3] && !ha[n-4];
      eb   = hb[n-3] && !hb[n-4];
      m_din = 2'd0;
      m_rej = 1'b0;
      if (ev5 && ev10) m_rej = 1'b1;
      else if (m_state == 0) begin
        m_rej = ev5 || ev10;
        if (ea != eb) begin m_sel = eb; m_state = 1; end
      end else if (m_state == 1) begin
        if (ev5 || ev10) begin m_din = ev10 ? 2'd2 : 2'd1; m_state = 2; end
        else if (ea != eb) m_sel = eb;
      end else begin
        if (bus.drinks_out != 2'd0) begin m_rej = ev5 || ev10; m_state = 0; end
        else if (ev5 || ev10) m_din = ev10 ? 2'd2 : 2'd1;
      end
      m_valid = (m_state != 0);
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=00000", {bus.sel, bus.sel_valid, bus.din, bus.coin_reject});
    end
    checks++;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
    end
  endtask

  task automatic test_coin_latency;
    bus.btn_b = 1'b1;
    @(negedge clk);
    bus.btn_b = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL select_b_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
    end
    if ({bus.sel, bus.sel_valid} !== 2'b11) begin
      failures++; $display("FAIL sel_before_din got=%b exp=11", {bus.sel, bus.sel_valid});
    end
    checks++;
    bus.coin10_in = 1'b1;
    for (int k = 1; k <= D + 8; k++) begin
      @(negedge clk);
      if (bus.din !== ((k == D + 4) ? 2'd2 : 2'd0)) begin
        failures++; $display("FAIL din_latency edge=E+%0d got=%0d exp=%0d", k - 1, bus.din, (k == D + 4) ? 2 : 0);
      end
      checks++;
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL latency_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
      if (k == 10) bus.coin10_in = 1'b0;
    end
  endtask

  task automatic test_paying_locks;
    bus.btn_a = 1'b1;
    @(negedge clk);
    bus.btn_a = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL paying_btn_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
    end
    if ({bus.sel, bus.sel_valid} !== 2'b11) begin
      failures++; $display("FAIL paying_sel_locked got=%b exp=11", {bus.sel, bus.sel_valid});
    end
    checks++;
    bus.drinks_out = 2'd2;
    @(negedge clk);
    if ({bus.sel, bus.sel_valid} !== 2'b10) begin
      failures++; $display("FAIL dispense_to_idle got=%b exp=10", {bus.sel, bus.sel_valid});
    end
    checks++;
    bus.drinks_out = 2'd0;
    repeat (4) begin
      @(negedge clk);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL idle_hold_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
    end
  endtask

  task automatic test_idle_reject;
    int rej = 0, dn = 0, vl = 0;
    bus.coin5_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rej += int'(bus.coin_reject);
      dn += int'(bus.din != 2'd0);
      vl += int'(bus.sel_valid);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL idle_reject_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
      if (k == 10) bus.coin5_in = 1'b0;
    end
    if (rej != 1 || dn != 0 || vl != 0) begin
      failures++; $display("FAIL idle_reject_counts rej=%0d din=%0d valid=%0d exp=1,0,0", rej, dn, vl);
    end
    checks++;
  endtask

  task automatic test_bounce;
    int rej = 0, dn = 0;
    bus.btn_a = 1'b1;
    @(negedge clk);
    bus.btn_a = 1'b0;
    repeat (6) @(negedge clk);
    if ({bus.sel, bus.sel_valid} !== 2'b01) begin
      failures++; $display("FAIL select_a got=%b exp=01", {bus.sel, bus.sel_valid});
    end
    checks++;
    for (int k = 1; k <= 30; k++) begin
      bus.coin5_in = (k <= 20) ? k[0] : 1'b0;
      @(negedge clk);
      rej += int'(bus.coin_reject);
      dn += int'(bus.din != 2'd0);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
    end
    if (rej != 0 || dn != 0) begin
      failures++; $display("FAIL bounce_counts rej=%0d din=%0d exp=0,0", rej, dn);
    end
    checks++;
  endtask

  task automatic test_both_coins;
    int rej = 0, dn = 0;
    bus.coin5_in = 1'b1;
    bus.coin10_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      rej += int'(bus.coin_reject);
      dn += int'(bus.din != 2'd0);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL both_coins_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
      if (k == 10) begin bus.coin5_in = 1'b0; bus.coin10_in = 1'b0; end
    end
    if (rej != 1 || dn != 0 || bus.sel_valid !== 1'b1) begin
      failures++; $display("FAIL both_coins_counts rej=%0d din=%0d valid=%b exp=1,0,1", rej, dn, bus.sel_valid);
    end
    checks++;
    bus.btn_b = 1'b1;
    @(negedge clk);
    bus.btn_b = 1'b0;
    repeat (6) @(negedge clk);
    if ({bus.sel, bus.sel_valid} !== 2'b11) begin
      failures++; $display("FAIL still_selected_reselect got=%b exp=11", {bus.sel, bus.sel_valid});
    end
    checks++;
  endtask

  task automatic test_reset_mid;
    int dn = 0, vl = 0;
    bus.coin5_in = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL pay5_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
      if (k == 10) bus.coin5_in = 1'b0;
    end
    bus.coin10_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== 5'b0) begin
      failures++; $display("FAIL mid_reset_outputs got=%b exp=00000", {bus.sel, bus.sel_valid, bus.din, bus.coin_reject});
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      dn += int'(bus.din != 2'd0);
      vl += int'(bus.sel_valid);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL post_reset_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
    end
    if (dn != 0 || vl != 0) begin
      failures++; $display("FAIL post_reset_counts din=%0d valid=%0d exp=0,0", dn, vl);
    end
    checks++;
    bus.coin10_in = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random;
    int hold5 = 0, hold10 = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if ({bus.sel, bus.sel_valid, bus.din, bus.coin_reject} !== {m_sel, m_valid, m_din, m_rej}) begin
        failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc, {bus.sel, bus.sel_valid, bus.din, bus.coin_reject}, {m_sel, m_valid, m_din, m_rej});
      end
      checks++;
      if (bus.din != 2'd0 && bus.coin_reject) begin
        failures++; $display("FAIL din_reject_exclusive cyc=%0d din=%0d rej=1 exp rej=0", cyc, bus.din);
      end
      checks++;
      if (hold5 == 0) begin bus.coin5_in = 1'($urandom_range(0, 1)); hold5 = $urandom_range(1, 12); end
      if (hold10 == 0) begin bus.coin10_in = 1'($urandom_range(0, 1)); hold10 = $urandom_range(1, 12); end
      hold5--;
      hold10--;
      bus.btn_a = ($urandom_range(0, 19) == 0);
      bus.btn_b = ($urandom_range(0, 19) == 0);
      bus.drinks_out = ($urandom_range(0, 24) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    end
  endtask

  initial begin
    bus.coin5_in = 1'b0;
    bus.coin10_in = 1'b0;
    bus.btn_a = 1'b0;
    bus.btn_b = 1'b0;
    bus.drinks_out = 2'd0;
    test_reset;
    test_coin_latency;
    test_paying_locks;
    test_idle_reject;
    test_bounce;
    test_both_coins;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coin_front.md
COIN_FRONT -- requirements
Module: coin_front

Interface
REQ-001 Parameter DEB_CYCLES, default 4, range 2..255: number of consecutive stable cycles needed to accept a coin-input level change.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 coin5_in  input  1  raw 5-yuan coin sensor, asynchronous, bouncy; high = coin present.
REQ-005 coin10_in  input  1  raw 10-yuan coin sensor, asynchronous, bouncy; high = coin present.
REQ-006 btn_a  input  1  raw "drink A" button, asynchronous, high = pressed.
REQ-007 btn_b  input  1  raw "drink B" button, asynchronous, high = pressed.
REQ-008 drinks_out  input  2  dispense code returned by the downstream vending FSM; nonzero = transaction finished.
REQ-009 sel  output  1  drink selection to the vending FSM: 0 = A (5 yuan), 1 = B (10 yuan).
REQ-010 din  output  2  coin code to the vending FSM: 0 none, 1 = 5 yuan, 2 = 10 yuan; never 3.
REQ-011 sel_valid  output  1  high while a selection is held (states SELECTED, PAYING).
REQ-012 coin_reject  output  1  one-cycle pulse: a detected coin was not forwarded and must be returned.

Function
REQ-013 Each of coin5_in, coin10_in, btn_a, btn_b SHALL pass through a two-flop synchronizer before any use.
REQ-014 Each coin channel SHALL hold a debounced level; it updates only after the synchronized value has differed from it for DEB_CYCLES consecutive cycles; any agreement cycle clears that channel's counter.
REQ-015 A coin event SHALL be a 0->1 transition of a debounced coin level; falling transitions generate nothing.
REQ-016 A button event SHALL be a 0->1 transition of the synchronized button (no debounce counter).
REQ-017 FSM states: IDLE, SELECTED, PAYING; reset state IDLE.
REQ-018 IDLE: btn_a event -> sel<=0, go SELECTED; btn_b event -> sel<=1, go SELECTED; both in same cycle -> ignored, stay IDLE.
REQ-019 IDLE: any coin event -> coin_reject pulse, no din, stay IDLE.
REQ-020 SELECTED: single button event SHALL update sel (reselection allowed); both same cycle -> ignored.
REQ-021 SELECTED or PAYING: single coin event -> din = 1 (5) or 2 (10) for exactly one cycle, next state PAYING.
REQ-022 Coin5 and coin10 events in the same cycle, any state -> both rejected: one coin_reject pulse, din stays 0, no state change.
REQ-023 PAYING: button events SHALL be ignored; sel SHALL not change.
REQ-024 PAYING: drinks_out != 0 -> next state IDLE; a coin event in that same cycle is rejected (coin_reject), not forwarded.
REQ-025 sel SHALL keep its last value in IDLE (never glitches after a transaction); sel changes only in the cycle it transitions per REQ-018/020, i.e. always at least one cycle before the first din of a transaction.
REQ-026 din, coin_reject, sel, sel_valid SHALL be registered outputs; din and coin_reject are never high in the same cycle.
REQ-027 Latency: coin input held high from first sampling edge E -> din high on edge E+DEB_CYCLES+3, for one cycle only.
REQ-028 Input pulses shorter than DEB_CYCLES cycles after synchronization SHALL produce no event.

Reset
REQ-029 While rst_n low: state IDLE, sel=0, sel_valid=0, din=0, coin_reject=0, synchronizers, debounced levels and counters all 0.
REQ-030 Reset asserted mid-transaction SHALL abandon it immediately; no din or coin_reject pulse is produced by the abandoned coins after release unless the input makes a fresh 0->1 debounced transition.

Verification
REQ-031 Reset, btn_b pulse, then coin10_in high 10 cycles -> sel=1, sel_valid=1 before din; din=2 for one cycle at E+DEB_CYCLES+3; state PAYING.
REQ-032 IDLE, coin5_in high 10 cycles, no button -> coin_reject=1 one cycle, din stays 0, sel_valid=0.
REQ-033 SELECTED (sel=0), coin5_in toggling every cycle for 20 cycles then low -> no din, no coin_reject.
REQ-034 PAYING with sel=1, btn_a pulse -> sel stays 1; then drinks_out=2 one cycle -> sel_valid=0 next cycle, sel still 1.
REQ-035 SELECTED, coin5_in and coin10_in rise on same edge, held 10 cycles -> single coin_reject pulse, din=0, state SELECTED.
REQ-036 PAYING, assert rst_n low for 2 cycles while coin10 debounce in progress -> all outputs 0, state IDLE, no din after release while coin10_in stays high.
